arc4_encrypt: RTL and testbench

ARC4_ENCRYPT -- requirements
Module: arc4_encrypt

---
 rtl/arc4_encrypt.sv | 258 +++++++++++++++++++++++++
 tb/tb_arc4_encrypt.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_encrypt.sv
// ---------------------------------------------------------------------------
// arc4_encrypt
//   RC4 (ARC4) stream cipher engine driving three external synchronous RAMs.
//   A length-prefixed message pt[0]=L, pt[1..L] is encrypted into ct[0..L]
//   (ct[0]=L, ct[k]=pt[k] ^ keystream[k]).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   en / rdy            start request (taken only while rdy=1) / idle flag
//   key                 8*KEY_LEN bit key, byte 0 in the MSBs
//   s_addr/s_wrdata/s_wren/s_rddata   256x8 state RAM, one-cycle read latency
//   pt_addr/pt_rddata   plaintext RAM read port, one-cycle read latency
//   ct_addr/ct_wrdata/ct_wren         ciphertext RAM write port
//
// All RAM-facing outputs are decoded combinationally from the registered
// state, so an asserted rst_n drops them to zero without waiting for a clock.
// Each state is split into sub-steps (step_q); a read address issued in one
// step is consumed from the RAM data bus in the following step.
// ---------------------------------------------------------------------------
module arc4_encrypt #(
    parameter int KEY_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_LEN-1:0]   key,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_LEN,
        ST_PRGA,
        ST_DONE
    } state_t;

    state_t state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] k_q, k_d;
    logic [7:0] kidx_q, kidx_d;

    logic [8*KEY_LEN-1:0] key_q, key_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] pt_q, pt_d;
    logic [7:0] len_q, len_d;

    logic [7:0] key_byte;

    // kidx_q tracks i mod KEY_LEN incrementally, avoiding a divider.
    assign key_byte = key_q[8*(KEY_LEN-1-int'(kidx_q)) +: 8];

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        kidx_d    = kidx_q;
        key_d     = key_q;
        si_d      = si_q;
        sj_d      = sj_q;
        pt_d      = pt_q;
        len_d     = len_q;
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        pt_addr   = 8'd0;
        ct_addr   = 8'd0;
        ct_wrdata = 8'd0;
        ct_wren   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    key_d   = key;
                    state_d = ST_INIT;
                    step_d  = 3'd0;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                end
            end

            ST_INIT: begin
                s_addr   = i_q;
                s_wrdata = i_q;
                s_wren   = 1'b1;
                i_d      = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    state_d = ST_KSA;
                    step_d  = 3'd0;
                    j_d     = 8'd0;
                    kidx_d  = 8'd0;
                end
            end

            ST_KSA: begin
                case (step_q)
                    3'd0: begin
                        s_addr = i_q;
                        step_d = 3'd1;
                    end
                    3'd1: begin
                        si_d   = s_rddata;
                        j_d    = j_q + s_rddata + key_byte;
                        step_d = 3'd2;
                    end
                    3'd2: begin
                        s_addr = j_q;
                        step_d = 3'd3;
                    end
                    3'd3: begin
                        // s[i] <= s[j]; when i==j both writes store the same byte.
                        sj_d     = s_rddata;
                        s_addr   = i_q;
                        s_wrdata = s_rddata;
                        s_wren   = 1'b1;
                        step_d   = 3'd4;
                    end
                    3'd4: begin
                        s_addr   = j_q;
                        s_wrdata = si_q;
                        s_wren   = 1'b1;
                        step_d   = 3'd0;
                        i_d      = i_q + 8'd1;
                        kidx_d   = (kidx_q == 8'(KEY_LEN-1)) ? 8'd0 : kidx_q + 8'd1;
                        if (i_q == 8'hFF) begin
                            state_d = ST_LEN;
                        end
                    end
                    default: step_d = 3'd0;
                endcase
            end

            ST_LEN: begin
                if (step_q == 3'd0) begin
                    pt_addr = 8'd0;
                    step_d  = 3'd1;
                end else begin
                    len_d     = pt_rddata;
                    ct_addr   = 8'd0;
                    ct_wrdata = pt_rddata;
                    ct_wren   = 1'b1;
                    step_d    = 3'd0;
                    i_d       = 8'd0;
                    j_d       = 8'd0;
                    k_d       = 8'd1;
                    state_d   = (pt_rddata == 8'd0) ? ST_DONE : ST_PRGA;
                end
            end

            ST_PRGA: begin
                case (step_q)
                    3'd0: begin
                        s_addr = i_q + 8'd1;
                        i_d    = i_q + 8'd1;
                        step_d = 3'd1;
                    end
                    3'd1: begin
                        si_d   = s_rddata;
                        j_d    = j_q + s_rddata;
                        step_d = 3'd2;
                    end
                    3'd2: begin
                        s_addr  = j_q;
                        pt_addr = k_q;
                        step_d  = 3'd3;
                    end
                    3'd3: begin
                        sj_d     = s_rddata;
                        pt_d     = pt_rddata;
                        s_addr   = i_q;
                        s_wrdata = s_rddata;
                        s_wren   = 1'b1;
                        step_d   = 3'd4;
                    end
                    3'd4: begin
                        s_addr   = j_q;
                        s_wrdata = si_q;
                        s_wren   = 1'b1;
                        step_d   = 3'd5;
                    end
                    3'd5: begin
                        // Swapped pair has the same sum, so the pre-swap copies index the pad.
                        s_addr = si_q + sj_q;
                        step_d = 3'd6;
                    end
                    3'd6: begin
                        ct_addr   = k_q;
                        ct_wrdata = pt_q ^ s_rddata;
                        ct_wren   = 1'b1;
                        step_d    = 3'd0;
                        k_d       = k_q + 8'd1;
                        if (k_q == len_q) begin
                            state_d = ST_DONE;
                        end
                    end
                    default: step_d = 3'd0;
                endcase
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                step_d  = 3'd0;
                i_d     = 8'd0;
                j_d     = 8'd0;
            end

            default: begin
                state_d = ST_IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= 3'd0;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 8'd0;
            kidx_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            kidx_q  <= kidx_d;
        end
    end

    // Datapath holding registers: always written before use, so no reset.
    always_ff @(posedge clk) begin
        key_q <= key_d;
        si_q  <= si_d;
        sj_q  <= sj_d;
        pt_q  <= pt_d;
        len_q <= len_d;
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// ---------------------------------------------------------------------------
// tb_arc4_encrypt
//   Drives arc4_encrypt against behavioural RAMs and compares every ct write
//   with a plain-array RC4 reference model (or the published test vector).
// ---------------------------------------------------------------------------
module tb_arc4_encrypt;

    localparam int KEY_LEN = 3;
    localparam int TMO     = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  s_addr, s_wrdata, s_rddata;
    logic        s_wren;
    logic [7:0]  pt_addr, pt_rddata;
    logic [7:0]  ct_addr, ct_wrdata;
    logic        ct_wren;

    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];
    logic [7:0] exp_ct [256];
    logic [7:0] orig   [256];
    logic [7:0] log_a [$];
    logic [7:0] log_d [$];

    int vectors     = 0;
    int miscompares = 0;

    arc4_encrypt #(.KEY_LEN(KEY_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
        .pt_addr(pt_addr), .pt_rddata(pt_rddata),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
    );

    always #5 clk = ~clk;

    // Synchronous RAMs, read data one cycle after the address.
    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (ct_wren) begin
            log_a.push_back(ct_addr);
            log_d.push_back(ct_wrdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rdy"}, 32'(rdy), 1);
        check({tag, "_s_wren"}, 32'(s_wren), 0);
        check({tag, "_ct_wren"}, 32'(ct_wren), 0);
        check({tag, "_addrs"}, {8'(s_addr), 8'(pt_addr), 8'(ct_addr), 8'h00}, 0);
        check({tag, "_wrdata"}, {16'h0, 8'(s_wrdata), 8'(ct_wrdata)}, 0);
    endtask

    // RC4 straight from its definition on plain integer arrays.
    task automatic model(input logic [23:0] k);
        int S[256];
        int i, j, t, L, kb;
        for (int n = 0; n < 256; n++) S[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            kb = int'((k >> (8 * (KEY_LEN - 1 - (n % KEY_LEN)))) & 24'hFF);
            j = (j + S[n] + kb) % 256;
            t = S[n]; S[n] = S[j]; S[j] = t;
        end
        L = int'(pt_mem[0]);
        exp_ct[0] = pt_mem[0];
        i = 0;
        j = 0;
        for (int n = 1; n <= L; n++) begin
            i = (i + 1) % 256;
            j = (j + S[i]) % 256;
            t = S[i]; S[i] = S[j]; S[j] = t;
            exp_ct[n] = pt_mem[n] ^ 8'(S[(S[i] + S[j]) % 256]);
        end
    endtask

    task automatic fill_random(input int L);
        pt_mem[0] = 8'(L);
        for (int n = 1; n <= L; n++) pt_mem[n] = 8'($urandom);
    endtask

    // Start one message and wait for rdy; optionally hammer en/key meanwhile.
    task automatic run(input string tag, input logic [23:0] k, input bit disturb,
                       output int lat);
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        check({tag, "_rdy_clear"}, 32'(rdy), 0);
        lat = 1;
        while (rdy !== 1'b1 && lat < TMO) begin
            if (disturb) begin
                @(negedge clk);
                en  = 1'($urandom);
                key = 24'($urandom);
            end
            @(posedge clk);
            #1;
            en = 1'b0;
            lat++;
        end
        check({tag, "_done_in_time"}, 32'(rdy), 1);
    endtask

    task automatic check_msg(input string tag, input int base);
        int L;
        L = int'(pt_mem[0]);
        check({tag, "_ct_writes"}, 32'(log_a.size() - base), 32'(L + 1));
        for (int n = 0; n <= L; n++) begin
            if (base + n < log_a.size()) begin
                check($sformatf("%s_addr%0d", tag, n), 32'(log_a[base + n]), 32'(n));
                check($sformatf("%s_ct%0d", tag, n), 32'(log_d[base + n]), 32'(exp_ct[n]));
            end
        end
    endtask

    task automatic load_key_vector();
        logic [7:0] ptxt [10];
        logic [7:0] ctxt [10];
        ptxt = '{8'h09, "P", "l", "a", "i", "n", "t", "e", "x", "t"};
        ctxt = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int n = 0; n < 10; n++) begin
            pt_mem[n] = ptxt[n];
            exp_ct[n] = ctxt[n];
        end
    endtask

    initial begin
        int lat, base;

        // Reset with en held high: must stay idle, outputs quiet.
        rst_n = 1'b0;
        en    = 1'b1;
        key   = 24'h4B6579;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("en_in_reset_ignored", 32'(rdy), 1);

        // Published "Key"/"Plaintext" vector.
        load_key_vector();
        base = log_a.size();
        run("kv", 24'h4B6579, 1'b0, lat);
        check_msg("kv", base);
        check("kv_latency", 32'(lat <= 256 + 5*256 + 8*9 + 16), 1);
        @(posedge clk);
        #1;
        check("kv_rdy_stays", 32'(rdy), 1);

        // Empty message.
        pt_mem[0] = 8'd0;
        model(24'h123456);
        base = log_a.size();
        run("l0", 24'h123456, 1'b0, lat);
        check_msg("l0", base);
        check("l0_latency", 32'(lat <= 256 + 5*256 + 16), 1);

        // Random keys and lengths.
        for (int r = 0; r < 3; r++) begin
            logic [23:0] rk;
            rk = 24'($urandom);
            fill_random(int'($urandom_range(1, 40)));
            model(rk);
            base = log_a.size();
            run($sformatf("rnd%0d", r), rk, 1'b0, lat);
            check_msg($sformatf("rnd%0d", r), base);
        end

        // Round trip: encrypting the ciphertext restores the plaintext.
        fill_random(32);
        for (int n = 0; n <= 32; n++) orig[n] = pt_mem[n];
        model(24'h000018);
        base = log_a.size();
        run("rt1", 24'h000018, 1'b0, lat);
        check_msg("rt1", base);
        for (int n = 0; n <= 32; n++)
            pt_mem[n] = (base + n < log_d.size()) ? log_d[base + n] : 8'h00;
        for (int n = 0; n <= 32; n++) exp_ct[n] = orig[n];
        base = log_a.size();
        run("rt2", 24'h000018, 1'b0, lat);
        check_msg("rt2", base);

        // Longest message: addresses 0..255 exactly once.
        fill_random(255);
        model(24'hA5C3E1);
        base = log_a.size();
        run("l255", 24'hA5C3E1, 1'b0, lat);
        check_msg("l255", base);
        check("l255_latency", 32'(lat <= 256 + 5*256 + 8*255 + 16), 1);

        // en and key toggled throughout a run must not disturb it.
        fill_random(20);
        model(24'h0F1E2D);
        base = log_a.size();
        run("dist", 24'h0F1E2D, 1'b1, lat);
        check_msg("dist", base);
        repeat (2) @(posedge clk);
        #1;
        check("dist_no_restart", 32'(rdy), 1);
        check("dist_no_extra_ct", 32'(log_a.size() - base), 21);

        // Second message accepted normally afterwards.
        fill_random(5);
        model(24'h010203);
        base = log_a.size();
        run("second", 24'h010203, 1'b0, lat);
        check_msg("second", base);

        // Abort during KSA, then a clean run reproduces the vector.
        load_key_vector();
        @(negedge clk);
        key = 24'h4B6579;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (600) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        @(negedge clk);
        rst_n = 1'b1;
        base = log_a.size();
        run("kv2", 24'h4B6579, 1'b0, lat);
        check_msg("kv2", base);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
